shr_frame_rx: RTL and testbench
===============================

# shr_frame_rx

Receive-side counterpart of the shift-register stimulus generator: samples the three-wire serial stream (serial clock, serial data, sync frame) on the board clock and reassembles each framed word into a parallel register. It sits on the target or loopback side of the GPIO header, in the same clock domain as the PLL output that drives the generator. It flags malformed frames and counts received words for LED and logic-analyser readout.

## Interface

- WIDTH, 16, bits per frame; legal range 2..32
- CNT_W, 8, width of the received-word counter

- clk_in  input  1  system clock (PLL output); all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_clk  input  1  serial clock from the header; asynchronous
- s_din  input  1  serial data; asynchronous
- s_syn  input  1  frame sync, high for the duration of a word; asynchronous
- data  output  WIDTH  last good word, MSB = first bit received
- data_valid  output  1  one-cycle pulse when `data` updates
- frame_err  output  1  one-cycle pulse on a malformed frame
- busy  output  1  high while a frame is open
- word_cnt  output  CNT_W  number of good words received, wraps

## Operation

- Input conditioning:
  - Each of s_clk, s_din and s_syn passes through a 2-FF synchronizer (stages s1 and s2), then a history register (s3).
  - rise(x) = s2 & ~s3; fall(x) = ~s2 & s3.
- State machine: IDLE, SHIFT.
  - IDLE: on rise(syn), go to SHIFT, clear the shift register and bit counter, and set busy.
  - In IDLE, s_clk edges are ignored.
  - A frame starts only on a syn rising edge, so a syn level that is already high at reset release is ignored until it falls and rises again.
  - SHIFT, on rise(clk) with syn still high: shift `{sr[WIDTH-2:0], din_s2}` and increment bit_cnt.
  - bit_cnt saturates at WIDTH+1. Once bit_cnt ≥ WIDTH, further bits neither shift nor alter sr; they only set the overflow condition (bit_cnt = WIDTH+1).
  - SHIFT, on fall(syn): return to IDLE and clear busy.
    - bit_cnt == WIDTH: load data ← sr, pulse data_valid, word_cnt ← word_cnt+1 (mod 2^CNT_W).
    - Otherwise (short, empty or overflowed frame): pulse frame_err; data and word_cnt are unchanged.
- Simultaneous rise(clk) and fall(syn) in the same cycle: the syn fall wins and that clock edge is not counted.
- data_valid and frame_err are never high in the same cycle.
- rst in any state:
  - next cycle: IDLE, all outputs 0, synchronizer and history registers 0;
  - no pulse is emitted for an interrupted frame.

## Timing

- Reset values: data = 0, data_valid = 0, frame_err = 0, busy = 0, word_cnt = 0.
- Latency, for a pin transition that is stable before clk_in edge k:
  - s2 reflects it after edge k+1;
  - the registered response (busy, shift, pulses) is visible after edge k+2.
  - busy rises 3 clk_in edges after the syn rising transition.
  - data_valid pulses 3 edges after the syn falling transition and lasts exactly 1 cycle.
- Input constraints, required for correct capture (not checked by the block):
  - s_clk high ≥ 2 and low ≥ 2 clk_in periods;
  - s_din stable ≥ 2 clk_in periods before and after the s_clk rising edge;
  - s_syn rises ≥ 2 clk_in periods before the first s_clk rise and falls ≥ 2 clk_in periods after the last.
- Back-to-back frames: syn low for ≥ 2 clk_in periods between frames is sufficient; no dead cycles are needed beyond that.

## Test plan

- Reset then idle: hold rst for 2 cycles, with s_clk toggling and syn low → all outputs 0 and word_cnt stays 0.
- Single good frame, WIDTH = 16: syn high, 16 s_clk rises shifting 0xA5C3 MSB-first, syn low → data = 0xA5C3, data_valid pulses 1 cycle exactly 3 edges after the syn fall, word_cnt = 1, busy is low afterwards.
- Short and long frames:
  - 15 bits → frame_err pulse, data keeps its previous value, word_cnt unchanged;
  - 17 bits → frame_err pulse;
  - syn high with 0 clocks → frame_err pulse.
- Edge collision: s_clk rise and syn fall land in the same synchronized cycle on the 17th edge of a 16-bit frame → that bit is ignored, data_valid fires, no frame_err.
- Reset mid-frame: assert rst after 8 bits with syn still high, release, then finish with 8 more bits and syn low → no data_valid and no frame_err; the next full frame is received correctly.
- Counter wrap: 256 consecutive good frames with CNT_W = 8 → word_cnt returns to 0 and data equals the last word.

Source files
------------

// File: rtl/shr_frame_rx.sv
// Serial frame receiver: synchronises a three-wire clock/data/sync stream onto clk_in
// and reassembles each framed word MSB-first, flagging frames with the wrong bit count.
module shr_frame_rx #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             s_clk,
    input  logic             s_din,
    input  logic             s_syn,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
);
    // state | meaning
    // IDLE  | waiting for a sync rising edge; serial clock ignored
    // SHIFT | frame open; one bit sampled per serial clock rise
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam int BCW = $clog2(WIDTH + 2);
    localparam logic [BCW-1:0] BITS_FULL = BCW'(WIDTH);
    localparam logic [BCW-1:0] BITS_OVF  = BCW'(WIDTH + 1);

    state_t           state, state_nxt;
    logic [2:0]       sync1, sync2;     // [0] clk, [1] din, [2] syn
    logic [1:0]       hist;             // [0] clk, [1] syn
    logic [1:0]       settle;
    logic             armed;
    logic [WIDTH-1:0] sr;
    logic [BCW-1:0]   bit_cnt;
    logic             clk_rise, syn_rise, syn_fall;
    logic             start, shift_bit, end_good, end_bad;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= {s_syn, s_din, s_clk};
            sync2 <= sync1;
            hist  <= {sync2[2], sync2[0]};
        end
    end

    assign clk_rise = sync2[0] & ~hist[0];
    assign syn_rise = sync2[2] & ~hist[1];
    assign syn_fall = ~sync2[2] & hist[1];

    // sync2 holds the real pin level only two edges after reset; a frame may open
    // only once sync has been seen low, so a level held high across reset is ignored
    always_ff @(posedge clk_in) begin
        if (rst) begin
            settle <= 2'd2;
            armed  <= 1'b0;
        end else if (settle != 2'd0) begin
            settle <= settle - 2'd1;
        end else if (!sync2[2]) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (syn_rise && armed) state_nxt = SHIFT;
            SHIFT:   if (syn_fall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // a sync fall takes priority over a serial clock rise in the same cycle
    always_comb begin
        start     = 1'b0;
        shift_bit = 1'b0;
        end_good  = 1'b0;
        end_bad   = 1'b0;
        case (state)
            IDLE: start = syn_rise & armed;
            SHIFT: begin
                if (syn_fall) begin
                    end_good = (bit_cnt == BITS_FULL);
                    end_bad  = (bit_cnt != BITS_FULL);
                end else if (clk_rise) begin
                    shift_bit = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sr         <= '0;
            bit_cnt    <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            word_cnt   <= '0;
        end else begin
            data_valid <= end_good;
            frame_err  <= end_bad;
            if (start) begin
                sr      <= '0;
                bit_cnt <= '0;
            end else if (shift_bit) begin
                if (bit_cnt < BITS_FULL) begin
                    sr      <= {sr[WIDTH-2:0], sync2[1]};
                    bit_cnt <= bit_cnt + BCW'(1);
                end else begin
                    bit_cnt <= BITS_OVF;
                end
            end
            if (end_good) begin
                data     <= sr;
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_shr_frame_rx.sv
// Randomised frame stimulus for shr_frame_rx, checked every cycle against an
// event-schedule model derived from pin timing, plus literal spot checks.
module tb_shr_frame_rx;
    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk_in = 1'b0;
    logic             rst    = 1'b1;
    logic             s_clk  = 1'b0;
    logic             s_din  = 1'b0;
    logic             s_syn  = 1'b0;
    logic [WIDTH-1:0] data;
    logic             data_valid, frame_err, busy;
    logic [CNT_W-1:0] word_cnt;

    shr_frame_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_in(clk_in), .rst(rst), .s_clk(s_clk), .s_din(s_din), .s_syn(s_syn),
        .data(data), .data_valid(data_valid), .frame_err(frame_err),
        .busy(busy), .word_cnt(word_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef enum int {EV_BUSY, EV_GOOD, EV_BAD} kind_t;
    typedef struct {
        int               at;
        kind_t            kind;
        logic [WIDTH-1:0] word;
    } ev_t;

    ev_t              evq[$];
    int               cyc = 0, checks = 0, errors = 0;
    logic             m_busy = 1'b0;
    logic [WIDTH-1:0] m_data = '0;
    logic [CNT_W-1:0] m_cnt  = '0;
    logic             e_dv, e_fe;
    int               dv_seen = 0, fe_seen = 0, last_dv_edge = -1, last_fall_edge = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: events scheduled by the stimulus at (pin edge + 2) take effect on that edge
    always @(posedge clk_in) begin
        ev_t ev;
        cyc++;
        e_dv = 1'b0;
        e_fe = 1'b0;
        if (rst) begin
            evq.delete();
            m_busy = 1'b0;
            m_data = '0;
            m_cnt  = '0;
        end else begin
            while (evq.size() > 0 && evq[0].at <= cyc) begin
                ev = evq.pop_front();
                case (ev.kind)
                    EV_BUSY: m_busy = 1'b1;
                    EV_GOOD: begin m_busy = 1'b0; e_dv = 1'b1; m_data = ev.word; m_cnt = m_cnt + 1'b1; end
                    default: begin m_busy = 1'b0; e_fe = 1'b1; end
                endcase
            end
        end
        #1;
        chk("data_valid", data_valid, e_dv);
        chk("frame_err", frame_err, e_fe);
        chk("busy", busy, m_busy);
        chk("data", data, m_data);
        chk("word_cnt", word_cnt, m_cnt);
        if (data_valid) begin dv_seen++; last_dv_edge = cyc; end
        if (frame_err) fe_seen++;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_bit(input logic b, input int lo, input int hi);
        s_din = b;
        wait_n(lo);
        s_clk = 1'b1;
        wait_n(hi);
        s_clk = 1'b0;
    endtask

    function automatic int dur(input bit fast);
        return fast ? 2 : int'($urandom_range(2, 4));
    endfunction

    task automatic push_ev(input int at, input kind_t kind, input logic [WIDTH-1:0] word);
        ev_t ev;
        ev.at = at; ev.kind = kind; ev.word = word;
        evq.push_back(ev);
    endtask

    // Sends nbits of pat MSB-first; collide adds one more clock rise landing with the sync fall
    task automatic send_frame(input int nbits, input logic [31:0] pat, input bit collide, input bit fast);
        int fall;
        @(negedge clk_in);
        s_syn = 1'b1;
        push_ev(cyc + 3, EV_BUSY, '0);
        for (int i = 0; i < nbits; i++) send_bit(pat[nbits-1-i], dur(fast), dur(fast));
        if (collide) begin
            s_din = 1'($urandom);
            wait_n(dur(fast));
            s_clk = 1'b1;
            s_syn = 1'b0;
            fall = cyc + 1;
            wait_n(2);
            s_clk = 1'b0;
        end else begin
            wait_n(dur(fast));
            s_syn = 1'b0;
            fall = cyc + 1;
        end
        last_fall_edge = fall;
        push_ev(fall + 2, (nbits == WIDTH) ? EV_GOOD : EV_BAD, pat[WIDTH-1:0]);
        wait_n(2);
        if (!fast && $urandom_range(0, 1) == 1) begin
            s_clk = 1'b1;
            wait_n(2);
            s_clk = 1'b0;
            wait_n(2);
        end
    endtask

    initial begin
        int dv0, nb, r;
        logic [31:0] pat, last_pat;
        bit col;

        @(negedge clk_in); s_clk = 1'b1;
        @(negedge clk_in); s_clk = 1'b0; rst = 1'b0;
        s_clk = 1'b1; wait_n(2); s_clk = 1'b0; wait_n(3);
        chk("idle_word_cnt", word_cnt, 0);
        chk("idle_busy", busy, 0);
        chk("idle_data", data, 0);

        send_frame(16, 32'hA5C3, 1'b0, 1'b0);
        wait_n(3);
        chk("good_data", data, 32'hA5C3);
        chk("good_model_data", m_data, 32'hA5C3);
        chk("good_cnt", word_cnt, 1);
        chk("good_dv_latency", last_dv_edge, last_fall_edge + 2);
        chk("good_dv_pulses", dv_seen, 1);
        chk("good_busy_after", busy, 0);

        send_frame(15, 32'h1234, 1'b0, 1'b0);
        wait_n(3);
        chk("short_fe", fe_seen, 1);
        chk("short_data", data, 32'hA5C3);
        chk("short_cnt", word_cnt, 1);
        send_frame(17, 32'h1FFFF, 1'b0, 1'b0);
        wait_n(3);
        chk("long_fe", fe_seen, 2);
        send_frame(0, 32'h0, 1'b0, 1'b0);
        wait_n(3);
        chk("empty_fe", fe_seen, 3);
        chk("empty_cnt", word_cnt, 1);

        send_frame(16, 32'h3C5A, 1'b1, 1'b0);
        wait_n(3);
        chk("collide_data", data, 32'h3C5A);
        chk("collide_cnt", word_cnt, 2);
        chk("collide_fe", fe_seen, 3);

        dv0 = dv_seen;
        @(negedge clk_in);
        s_syn = 1'b1;
        push_ev(cyc + 3, EV_BUSY, '0);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 2, 2);
        @(negedge clk_in); rst = 1'b1;
        wait_n(2); rst = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 2, 2);
        wait_n(2); s_syn = 1'b0;
        wait_n(4);
        chk("midrst_dv", dv_seen, dv0);
        chk("midrst_fe", fe_seen, 3);
        chk("midrst_cnt", word_cnt, 0);
        send_frame(16, 32'hBEEF, 1'b0, 1'b0);
        wait_n(3);
        chk("after_rst_data", data, 32'hBEEF);
        chk("after_rst_cnt", word_cnt, 1);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            nb = (r <= 5) ? 16 : (r == 6) ? 15 : (r == 7) ? 17 : (r == 8) ? 0 : int'($urandom_range(1, 20));
            pat = $urandom;
            col = (nb == 16) && ($urandom_range(0, 3) == 0);
            send_frame(nb, pat, col, 1'b0);
        end

        @(negedge clk_in); rst = 1'b1;
        wait_n(2); rst = 1'b0;
        wait_n(4);
        dv0 = dv_seen;
        last_pat = 32'h0;
        for (int k = 0; k < 256; k++) begin
            pat = $urandom;
            last_pat = pat;
            send_frame(16, pat, 1'b0, 1'b1);
        end
        wait_n(3);
        chk("wrap_cnt", word_cnt, 0);
        chk("wrap_data", data, {16'h0, last_pat[15:0]});
        chk("wrap_dv_pulses", dv_seen - dv0, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
